// File: rtl/packet_body_processor_queued.sv
// ---------------------------------------------------------------------------
// packet_body_processor_queued
//
// Buffers packet body beats in an AXI-Stream FIFO and the per-packet header
// (MACs, IPs, L4 ports) in a metadata FIFO. The header is captured on the
// first beat handshake of each packet. On the output side, the header of the
// packet currently being emitted is presented until its tlast handshake.
// With SWAP_ADDRS=1 the source and destination fields are exchanged on output.
//
// Ports
//   axis_aclk / axis_resetn        clock, asynchronous active-low reset
//   *_addr_in, *_port_in           header fields, sampled on first-beat handshake
//   packet_body_in_axis_*          input AXI-Stream (tdata/tkeep/tuser/tlast)
//   *_addr_out, *_port_out         header of packet at the output
//   header_out_valid               metadata FIFO non-empty
//   packet_body_out_axis_*         output AXI-Stream, first-word-fall-through
//   packet_count                   packets completed at output, wraps
// ---------------------------------------------------------------------------

// FIFO occupancy invariants; never synthesised into logic.
module packet_body_processor_queued_chk (
  input logic clk,
  input logic rst_n,
  input logic body_push,
  input logic body_pop,
  input logic body_full,
  input logic body_empty,
  input logic meta_push,
  input logic meta_pop,
  input logic meta_full,
  input logic meta_empty,
  input logic out_valid,
  input logic hdr_valid
);
  // Sample the invariants on every active edge outside reset.
  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(body_push && body_full));
      assert (!(body_pop && body_empty));
      assert (!(meta_push && meta_full));
      assert (!(meta_pop && meta_empty));
      assert (!out_valid || hdr_valid);
    end
  end
endmodule

module packet_body_processor_queued #(
  parameter int TDATA_WIDTH = 256,
  parameter int TUSER_WIDTH = 128,
  parameter int BODY_DEPTH  = 16,
  parameter int META_DEPTH  = 4,
  parameter int SWAP_ADDRS  = 0
) (
  input  logic                     axis_aclk,
  input  logic                     axis_resetn,
  input  logic [47:0]              src_mac_addr_in,
  input  logic [47:0]              dest_mac_addr_in,
  input  logic [31:0]              src_ip_addr_in,
  input  logic [31:0]              dest_ip_addr_in,
  input  logic [15:0]              src_port_in,
  input  logic [15:0]              dest_port_in,
  input  logic [TDATA_WIDTH-1:0]   packet_body_in_axis_tdata,
  input  logic [TDATA_WIDTH/8-1:0] packet_body_in_axis_tkeep,
  input  logic [TUSER_WIDTH-1:0]   packet_body_in_axis_tuser,
  input  logic                     packet_body_in_axis_tvalid,
  output logic                     packet_body_in_axis_tready,
  input  logic                     packet_body_in_axis_tlast,
  output logic [47:0]              src_mac_addr_out,
  output logic [47:0]              dest_mac_addr_out,
  output logic [31:0]              src_ip_addr_out,
  output logic [31:0]              dest_ip_addr_out,
  output logic [15:0]              src_port_out,
  output logic [15:0]              dest_port_out,
  output logic                     header_out_valid,
  output logic [TDATA_WIDTH-1:0]   packet_body_out_axis_tdata,
  output logic [TDATA_WIDTH/8-1:0] packet_body_out_axis_tkeep,
  output logic [TUSER_WIDTH-1:0]   packet_body_out_axis_tuser,
  output logic                     packet_body_out_axis_tvalid,
  input  logic                     packet_body_out_axis_tready,
  output logic                     packet_body_out_axis_tlast,
  output logic [31:0]              packet_count
);

  localparam int TKEEP_WIDTH       = TDATA_WIDTH / 8;
  localparam int MAC_ADDRESS_WIDTH = 48;
  localparam int IP_ADDRESS_WIDTH  = 32;
  localparam int PORT_WIDTH        = 16;
  localparam int HDR_W  = 2 * (MAC_ADDRESS_WIDTH + IP_ADDRESS_WIDTH + PORT_WIDTH);
  localparam int BEAT_W = TDATA_WIDTH + TKEEP_WIDTH + TUSER_WIDTH + 1;
  localparam int BODY_AW = $clog2(BODY_DEPTH);
  localparam int META_AW = $clog2(META_DEPTH);

  // Storage and pointers (one extra pointer bit distinguishes full from empty).
  logic [BEAT_W-1:0] r_body_mem [BODY_DEPTH];
  logic [HDR_W-1:0]  r_meta_mem [META_DEPTH];
  logic [BODY_AW:0]  r_body_wr;
  logic [BODY_AW:0]  r_body_rd;
  logic [META_AW:0]  r_meta_wr;
  logic [META_AW:0]  r_meta_rd;
  logic              r_in_sop;
  logic              r_live;
  logic [31:0]       r_packet_count;

  logic              w_body_empty;
  logic              w_body_full;
  logic              w_meta_empty;
  logic              w_meta_full;
  logic              w_in_ready;
  logic              w_in_hs;
  logic              w_meta_push;
  logic              w_out_valid;
  logic              w_out_hs;
  logic              w_meta_pop;
  logic [BEAT_W-1:0] w_body_head;
  logic [HDR_W-1:0]  w_meta_head;
  logic [BEAT_W-1:0] w_in_beat;
  logic [HDR_W-1:0]  w_in_hdr;

  assign w_body_empty = (r_body_wr == r_body_rd);
  assign w_body_full  = (r_body_wr[BODY_AW] != r_body_rd[BODY_AW]) &&
                        (r_body_wr[BODY_AW-1:0] == r_body_rd[BODY_AW-1:0]);
  assign w_meta_empty = (r_meta_wr == r_meta_rd);
  assign w_meta_full  = (r_meta_wr[META_AW] != r_meta_rd[META_AW]) &&
                        (r_meta_wr[META_AW-1:0] == r_meta_rd[META_AW-1:0]);

  // Ready depends only on registered state, so a pop in the same cycle does
  // not free a slot for the input; r_live keeps tready low while in reset.
  assign w_in_ready  = r_live && !w_body_full && (!r_in_sop || !w_meta_full);
  assign w_in_hs     = packet_body_in_axis_tvalid && w_in_ready;
  assign w_meta_push = w_in_hs && r_in_sop;

  assign w_body_head = r_body_mem[r_body_rd[BODY_AW-1:0]];
  assign w_meta_head = r_meta_mem[r_meta_rd[META_AW-1:0]];
  assign w_out_valid = !w_body_empty;
  assign w_out_hs    = w_out_valid && packet_body_out_axis_tready;
  assign w_meta_pop  = w_out_hs && w_body_head[0];

  assign w_in_beat = {packet_body_in_axis_tdata, packet_body_in_axis_tkeep,
                      packet_body_in_axis_tuser, packet_body_in_axis_tlast};
  assign w_in_hdr  = {src_mac_addr_in, dest_mac_addr_in, src_ip_addr_in,
                      dest_ip_addr_in, src_port_in, dest_port_in};

  assign packet_body_in_axis_tready  = w_in_ready;
  assign packet_body_out_axis_tvalid = w_out_valid;
  assign header_out_valid            = !w_meta_empty;
  assign packet_count                = r_packet_count;

  // Body and metadata storage writes (contents need no reset; pointers gate use).
  always_ff @(posedge axis_aclk) begin
    if (w_in_hs) begin
      r_body_mem[r_body_wr[BODY_AW-1:0]] <= w_in_beat;
    end
    if (w_meta_push) begin
      r_meta_mem[r_meta_wr[META_AW-1:0]] <= w_in_hdr;
    end
  end

  // Pointers, start-of-packet tracking and completed-packet counter.
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      r_body_wr      <= {(BODY_AW+1){1'b0}};
      r_body_rd      <= {(BODY_AW+1){1'b0}};
      r_meta_wr      <= {(META_AW+1){1'b0}};
      r_meta_rd      <= {(META_AW+1){1'b0}};
      r_in_sop       <= 1'b1;
      r_live         <= 1'b0;
      r_packet_count <= 32'd0;
    end else begin
      r_live <= 1'b1;
      if (w_in_hs) begin
        r_body_wr <= r_body_wr + {{BODY_AW{1'b0}}, 1'b1};
        r_in_sop  <= packet_body_in_axis_tlast;
      end
      if (w_meta_push) begin
        r_meta_wr <= r_meta_wr + {{META_AW{1'b0}}, 1'b1};
      end
      if (w_out_hs) begin
        r_body_rd <= r_body_rd + {{BODY_AW{1'b0}}, 1'b1};
      end
      if (w_meta_pop) begin
        r_meta_rd      <= r_meta_rd + {{META_AW{1'b0}}, 1'b1};
        r_packet_count <= r_packet_count + 32'd1;
      end
    end
  end

  // Output beat: FIFO head when non-empty, zero otherwise (no stale data).
  always_comb begin
    packet_body_out_axis_tdata = {TDATA_WIDTH{1'b0}};
    packet_body_out_axis_tkeep = {TKEEP_WIDTH{1'b0}};
    packet_body_out_axis_tuser = {TUSER_WIDTH{1'b0}};
    packet_body_out_axis_tlast = 1'b0;
    if (w_out_valid) begin
      packet_body_out_axis_tdata = w_body_head[BEAT_W-1 -: TDATA_WIDTH];
      packet_body_out_axis_tkeep = w_body_head[TUSER_WIDTH+1 +: TKEEP_WIDTH];
      packet_body_out_axis_tuser = w_body_head[1 +: TUSER_WIDTH];
      packet_body_out_axis_tlast = w_body_head[0];
    end else begin
      packet_body_out_axis_tlast = 1'b0;
    end
  end

  // Header outputs from the metadata head, optionally with src/dest exchanged.
  always_comb begin
    src_mac_addr_out  = 48'd0;
    dest_mac_addr_out = 48'd0;
    src_ip_addr_out   = 32'd0;
    dest_ip_addr_out  = 32'd0;
    src_port_out      = 16'd0;
    dest_port_out     = 16'd0;
    if (!w_meta_empty) begin
      if (SWAP_ADDRS != 0) begin
        src_mac_addr_out  = w_meta_head[143:96];
        dest_mac_addr_out = w_meta_head[191:144];
        src_ip_addr_out   = w_meta_head[63:32];
        dest_ip_addr_out  = w_meta_head[95:64];
        src_port_out      = w_meta_head[15:0];
        dest_port_out     = w_meta_head[31:16];
      end else begin
        src_mac_addr_out  = w_meta_head[191:144];
        dest_mac_addr_out = w_meta_head[143:96];
        src_ip_addr_out   = w_meta_head[95:64];
        dest_ip_addr_out  = w_meta_head[63:32];
        src_port_out      = w_meta_head[31:16];
        dest_port_out     = w_meta_head[15:0];
      end
    end else begin
      src_port_out = 16'd0;
    end
  end

  packet_body_processor_queued_chk u_chk (
    .clk        (axis_aclk),
    .rst_n      (axis_resetn),
    .body_push  (w_in_hs),
    .body_pop   (w_out_hs),
    .body_full  (w_body_full),
    .body_empty (w_body_empty),
    .meta_push  (w_meta_push),
    .meta_pop   (w_meta_pop),
    .meta_full  (w_meta_full),
    .meta_empty (w_meta_empty),
    .out_valid  (w_out_valid),
    .hdr_valid  (!w_meta_empty)
  );

endmodule

// File: tb/tb_packet_body_processor_queued.sv
// Bench for packet_body_processor_queued: a straight instance and a swapped
// instance share all inputs; a queue-based model predicts both.
module tb_packet_body_processor_queued;
  localparam int TDW = 32;
  localparam int TUW = 8;
  localparam int TKW = TDW / 8;
  localparam int BD  = 16;
  localparam int MD  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [47:0] i_smac, i_dmac;
  logic [31:0] i_sip, i_dip;
  logic [15:0] i_sport, i_dport;
  logic [TDW-1:0] i_data;
  logic [TKW-1:0] i_keep;
  logic [TUW-1:0] i_user;
  logic i_valid, i_last, o_ready;

  logic in_ready, hdr_valid, o_valid, o_last;
  logic [47:0] o_smac, o_dmac;
  logic [31:0] o_sip, o_dip, o_count;
  logic [15:0] o_sport, o_dport;
  logic [TDW-1:0] o_data;
  logic [TKW-1:0] o_keep;
  logic [TUW-1:0] o_user;

  logic s_in_ready, s_hdr_valid, s_valid, s_last;
  logic [47:0] s_smac, s_dmac;
  logic [31:0] s_sip, s_dip, s_count;
  logic [15:0] s_sport, s_dport;
  logic [TDW-1:0] s_data;
  logic [TKW-1:0] s_keep;
  logic [TUW-1:0] s_user;

  packet_body_processor_queued #(.TDATA_WIDTH(TDW), .TUSER_WIDTH(TUW), .BODY_DEPTH(BD),
    .META_DEPTH(MD), .SWAP_ADDRS(0)) dut (
    .axis_aclk(clk), .axis_resetn(rst_n),
    .src_mac_addr_in(i_smac), .dest_mac_addr_in(i_dmac),
    .src_ip_addr_in(i_sip), .dest_ip_addr_in(i_dip),
    .src_port_in(i_sport), .dest_port_in(i_dport),
    .packet_body_in_axis_tdata(i_data), .packet_body_in_axis_tkeep(i_keep),
    .packet_body_in_axis_tuser(i_user), .packet_body_in_axis_tvalid(i_valid),
    .packet_body_in_axis_tready(in_ready), .packet_body_in_axis_tlast(i_last),
    .src_mac_addr_out(o_smac), .dest_mac_addr_out(o_dmac),
    .src_ip_addr_out(o_sip), .dest_ip_addr_out(o_dip),
    .src_port_out(o_sport), .dest_port_out(o_dport),
    .header_out_valid(hdr_valid),
    .packet_body_out_axis_tdata(o_data), .packet_body_out_axis_tkeep(o_keep),
    .packet_body_out_axis_tuser(o_user), .packet_body_out_axis_tvalid(o_valid),
    .packet_body_out_axis_tready(o_ready), .packet_body_out_axis_tlast(o_last),
    .packet_count(o_count));

  packet_body_processor_queued #(.TDATA_WIDTH(TDW), .TUSER_WIDTH(TUW), .BODY_DEPTH(BD),
    .META_DEPTH(MD), .SWAP_ADDRS(1)) dut_sw (
    .axis_aclk(clk), .axis_resetn(rst_n),
    .src_mac_addr_in(i_smac), .dest_mac_addr_in(i_dmac),
    .src_ip_addr_in(i_sip), .dest_ip_addr_in(i_dip),
    .src_port_in(i_sport), .dest_port_in(i_dport),
    .packet_body_in_axis_tdata(i_data), .packet_body_in_axis_tkeep(i_keep),
    .packet_body_in_axis_tuser(i_user), .packet_body_in_axis_tvalid(i_valid),
    .packet_body_in_axis_tready(s_in_ready), .packet_body_in_axis_tlast(i_last),
    .src_mac_addr_out(s_smac), .dest_mac_addr_out(s_dmac),
    .src_ip_addr_out(s_sip), .dest_ip_addr_out(s_dip),
    .src_port_out(s_sport), .dest_port_out(s_dport),
    .header_out_valid(s_hdr_valid),
    .packet_body_out_axis_tdata(s_data), .packet_body_out_axis_tkeep(s_keep),
    .packet_body_out_axis_tuser(s_user), .packet_body_out_axis_tvalid(s_valid),
    .packet_body_out_axis_tready(o_ready), .packet_body_out_axis_tlast(s_last),
    .packet_count(s_count));

  typedef struct {
    logic [TDW-1:0] data;
    logic [TKW-1:0] keep;
    logic [TUW-1:0] user;
    logic           last;
    logic [191:0]   hdr;
  } beat_t;

  typedef struct {
    int          nbeats;
    int          npkts;
    bit          hold;
    logic [47:0] src_mac;
    logic [31:0] dest_ip;
    logic [15:0] src_port;
    logic [15:0] dest_port;
    int          exp_accept;
    int          exp_pkts;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  beat_t        src_q[$];
  beat_t        m_body[$];
  logic [191:0] m_hdr[$];
  logic [31:0]  m_count;
  bit           m_sop;
  bit           m_live;
  vec_t         vecs[8];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [191:0] rnd_hdr();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [191:0] swap_hdr(input logic [191:0] h);
    return {h[143:96], h[191:144], h[63:32], h[95:64], h[15:0], h[31:16]};
  endfunction

  task automatic model_reset();
    m_body.delete();
    m_hdr.delete();
    m_count = 32'd0;
    m_sop   = 1'b1;
    m_live  = 1'b0;
  endtask

  // Drive either the next queued beat or idle garbage.
  task automatic drive(input bit en);
    beat_t b;
    if (en && src_q.size() > 0) begin
      b = src_q[0];
      i_valid = 1'b1;
    end else begin
      b.data = TDW'($urandom);
      b.keep = TKW'($urandom);
      b.user = TUW'($urandom);
      b.last = 1'($urandom);
      b.hdr  = rnd_hdr();
      i_valid = 1'b0;
    end
    i_data = b.data;
    i_keep = b.keep;
    i_user = b.user;
    i_last = b.last;
    {i_smac, i_dmac, i_sip, i_dip, i_sport, i_dport} = b.hdr;
  endtask

  // Called at a falling edge with inputs driven: check outputs, then advance
  // the model across the next rising edge and return at the next falling edge.
  task automatic tick(output bit in_hs);
    bit exp_rdy, out_hs;
    beat_t cap, b;
    logic [191:0] h;
    exp_rdy = m_live && (m_body.size() < BD) && (!m_sop || m_hdr.size() < MD);
    chk("in_tready", {255'd0, in_ready}, {255'd0, exp_rdy});
    chk("sw_in_tready", {255'd0, s_in_ready}, {255'd0, exp_rdy});
    chk("out_tvalid", {255'd0, o_valid}, {255'd0, m_body.size() > 0});
    chk("sw_out_tvalid", {255'd0, s_valid}, {255'd0, m_body.size() > 0});
    chk("header_out_valid", {255'd0, hdr_valid}, {255'd0, m_hdr.size() > 0});
    chk("sw_header_out_valid", {255'd0, s_hdr_valid}, {255'd0, m_hdr.size() > 0});
    chk("packet_count", {224'd0, o_count}, {224'd0, m_count});
    chk("sw_packet_count", {224'd0, s_count}, {224'd0, m_count});
    if (m_body.size() > 0) begin
      b = m_body[0];
      chk("out_beat", {211'd0, o_data, o_keep, o_user, o_last}, {211'd0, b.data, b.keep, b.user, b.last});
      chk("sw_out_beat", {211'd0, s_data, s_keep, s_user, s_last}, {211'd0, b.data, b.keep, b.user, b.last});
    end
    if (m_hdr.size() > 0) begin
      h = m_hdr[0];
      chk("header_out", {64'd0, o_smac, o_dmac, o_sip, o_dip, o_sport, o_dport}, {64'd0, h});
      chk("sw_header_out", {64'd0, s_smac, s_dmac, s_sip, s_dip, s_sport, s_dport}, {64'd0, swap_hdr(h)});
    end
    in_hs  = i_valid && in_ready;
    out_hs = o_valid && o_ready;
    cap.data = i_data;
    cap.keep = i_keep;
    cap.user = i_user;
    cap.last = i_last;
    cap.hdr  = {i_smac, i_dmac, i_sip, i_dip, i_sport, i_dport};
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      if (out_hs && m_body.size() > 0) begin
        b = m_body.pop_front();
        if (b.last) begin
          if (m_hdr.size() > 0) void'(m_hdr.pop_front());
          m_count = m_count + 32'd1;
        end
      end
      if (in_hs) begin
        if (m_sop) m_hdr.push_back(cap.hdr);
        m_body.push_back(cap);
        m_sop = cap.last;
      end
      m_live = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic step(input bit en, output bit hs);
    drive(en);
    tick(hs);
    if (hs) void'(src_q.pop_front());
  endtask

  task automatic add_packet(input int n, input logic [191:0] hdr);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.data = TDW'($urandom);
      b.keep = TKW'($urandom);
      b.user = TUW'($urandom);
      b.last = (k == n - 1);
      b.hdr  = (k == 0) ? hdr : rnd_hdr();
      src_q.push_back(b);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic [191:0] h;
    logic [31:0] cnt0;
    int accepted, stall, guard;
    bit hs;
    for (int p = 0; p < v.npkts; p++) begin
      h = rnd_hdr();
      if (p == 0) begin
        h[191:144] = v.src_mac;
        h[63:32]   = v.dest_ip;
        h[31:16]   = v.src_port;
        h[15:0]    = v.dest_port;
      end
      add_packet(v.nbeats, h);
    end
    cnt0 = o_count;
    accepted = 0;
    stall = 0;
    guard = 0;
    o_ready = !v.hold;
    while (src_q.size() > 0 && stall < 4 && guard < 200) begin
      step(1'b1, hs);
      guard++;
      if (hs) begin
        accepted++;
        stall = 0;
      end else begin
        stall++;
      end
    end
    chk($sformatf("vec%0d_accepted_before_stall", idx), 256'(accepted), 256'(v.exp_accept));
    guard = 0;
    while ((src_q.size() > 0 || o_valid) && guard < 3000) begin
      o_ready = 1'($urandom_range(0, 1));
      step($urandom_range(0, 3) != 0, hs);
      guard++;
    end
    if (guard >= 3000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL vec%0d_drain_timeout: got %0d beats left expected 0", idx, src_q.size());
    end
    chk($sformatf("vec%0d_packet_delta", idx), 256'(o_count - cnt0), 256'(v.exp_pkts));
  endtask

  initial begin
    bit hs;
    int guard, got;
    vecs[0] = '{3, 1, 1'b0, 48'h0A0B0C0D0E0F, 32'hC0A80001, 16'h1234, 16'h0050, 3, 1};
    vecs[1] = '{1, 5, 1'b1, 48'h111111111111, 32'h01020304, 16'h0001, 16'h0002, 4, 5};
    vecs[2] = '{20, 1, 1'b1, 48'h222222222222, 32'h05060708, 16'h0003, 16'h0004, 16, 1};
    vecs[3] = '{4, 3, 1'b1, 48'h333333333333, 32'h090A0B0C, 16'h0005, 16'h0006, 12, 3};
    vecs[4] = '{6, 3, 1'b1, 48'h444444444444, 32'h0D0E0F10, 16'h0007, 16'h0008, 16, 3};
    vecs[5] = '{2, 4, 1'b1, 48'h555555555555, 32'h11121314, 16'h0009, 16'h000A, 8, 4};
    vecs[6] = '{1, 3, 1'b0, 48'h666666666666, 32'h15161718, 16'h000B, 16'h000C, 3, 3};
    vecs[7] = '{2, 1, 1'b0, 48'h112233445566, 32'h0A000002, 16'hBEEF, 16'h0001, 2, 1};

    rst_n = 1'b0;
    o_ready = 1'b0;
    model_reset();
    drive(1'b0);
    @(negedge clk);
    chk("reset_tready", {255'd0, in_ready}, 256'd0);
    chk("reset_tvalid", {255'd0, o_valid}, 256'd0);
    chk("reset_hdr_valid", {255'd0, hdr_valid}, 256'd0);
    chk("reset_count", {224'd0, o_count}, 256'd0);
    chk("reset_tdata", {224'd0, o_data}, 256'd0);
    chk("reset_src_mac", {208'd0, o_smac}, 256'd0);
    tick(hs);
    tick(hs);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Random traffic with random valid/ready.
    for (int p = 0; p < 30; p++) add_packet($urandom_range(1, 6), rnd_hdr());
    guard = 0;
    while ((src_q.size() > 0 || o_valid) && guard < 5000) begin
      o_ready = ($urandom_range(0, 3) != 0);
      step($urandom_range(0, 2) != 0, hs);
      guard++;
    end
    if (guard >= 5000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL random_drain_timeout: got %0d beats left expected 0", src_q.size());
    end

    // Reset in the middle of a 4-beat packet after 2 beats accepted.
    add_packet(4, rnd_hdr());
    o_ready = 1'b0;
    got = 0;
    guard = 0;
    while (got < 2 && guard < 50) begin
      step(1'b1, hs);
      if (hs) got++;
      guard++;
    end
    chk("midpkt_beats_buffered", {255'd0, o_valid}, 256'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_tvalid", {255'd0, o_valid}, 256'd0);
    chk("midrst_hdr_valid", {255'd0, hdr_valid}, 256'd0);
    chk("midrst_count", {224'd0, o_count}, 256'd0);
    chk("midrst_tready", {255'd0, in_ready}, 256'd0);
    chk("midrst_src_mac", {208'd0, o_smac}, 256'd0);
    src_q.delete();
    model_reset();
    drive(1'b0);
    @(negedge clk);
    tick(hs);
    rst_n = 1'b1;
    run_vec(7, vecs[7]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
